// File: rtl/boolean_bist_pkg.sv
// rtl/boolean_bist_pkg.sv - shared types, constants and truth-table lookup for boolean_bist
package boolean_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bist_state_e;

    localparam int DEFAULT_N_IN   = 3;
    localparam int NUM_VECTORS    = 1 << DEFAULT_N_IN;
    localparam int MAX_TABLE_BITS = 256;

    // (a & b) | c with stim = {a, b, c}
    localparam logic [NUM_VECTORS-1:0] DEFAULT_EXPECTED = 8'b1110_1010;

    function automatic logic expected_bit(input logic [MAX_TABLE_BITS-1:0] tbl, input logic [7:0] v);
        return tbl[v];
    endfunction

endpackage

// File: rtl/bist_hold_timer.sv
// rtl/bist_hold_timer.sv - per-vector hold counter, flags the last cycle of each hold
module bist_hold_timer #(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam int W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [W-1:0] LAST_COUNT = W'(HOLD_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign last = (count == LAST_COUNT);

endmodule

// File: rtl/boolean_bist.sv
// rtl/boolean_bist.sv - exhaustive-sweep self-test controller for a small combinational block
module boolean_bist
    import boolean_bist_pkg::*;
#(
    parameter int                      N_IN        = DEFAULT_N_IN,
    parameter logic [(1<<N_IN)-1:0]    EXPECTED    = DEFAULT_EXPECTED,
    parameter int                      HOLD_CYCLES = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int              VECTORS  = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(VECTORS - 1);

    bist_state_e state;
    bist_state_e next_state;

    logic          hold_last;
    logic          accept;
    logic          sample;
    logic          mismatch;
    logic          last_vec;
    logic [N_IN:0] fail_next;

    assign accept    = (state == IDLE) && start;
    assign sample    = (state == RUN) && hold_last;
    assign mismatch  = sample && (resp != expected_bit(MAX_TABLE_BITS'(EXPECTED), 8'(stim)));
    assign last_vec  = (stim == LAST_VEC);
    assign fail_next = fail_count + {{N_IN{1'b0}}, mismatch};

    // Cleared on every sample so each new vector starts a fresh hold
    bist_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(accept || sample),
        .en   (state == RUN),
        .last (hold_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (sample && last_vec) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stim             <= '0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (accept) begin
            stim             <= '0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (sample) begin
            fail_count <= fail_next;
            if (mismatch && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= stim;
            end
            // pass is decided on the edge that enters DONE so it is valid alongside done
            if (last_vec) begin
                pass <= (fail_next == '0);
            end else begin
                stim <= stim + N_IN'(1);
            end
        end
    end

endmodule

// File: tb/tb_boolean_bist.sv
// tb/tb_boolean_bist.sv - randomized self-checking bench for boolean_bist against a sweep-level model
module tb_boolean_bist;

    localparam int V = 8;

    logic clk;
    int   checks   = 0;
    int   failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int lane_id, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL lane%0d %s actual=%0d expected=%0d at %0t", lane_id, nm, act, want, $time);
        end
    endtask

    function automatic logic ref_fn(input logic [2:0] v);
        return (v[2] & v[1]) | v[0];
    endfunction

    // Block under test: 0 correct, 1 stuck-at-0, 2 inverted at one vector, 3 random fault mask
    function automatic logic blk(input logic [2:0] v, input int md, input logic [2:0] fvv, input logic [7:0] mk);
        case (md)
            0:       return ref_fn(v);
            1:       return 1'b0;
            2:       return ref_fn(v) ^ (v == fvv);
            default: return ref_fn(v) ^ mk[v];
        endcase
    endfunction

    function automatic int count_bad(input logic [7:0] b, input int s);
        int n = 0;
        for (int v = 0; v < s; v++) if (b[v]) n++;
        return n;
    endfunction

    function automatic int first_bad(input logic [7:0] b, input int s);
        for (int v = 0; v < s; v++) if (b[v]) return v;
        return -1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int H   = (g == 0) ? 20 : 1;
        localparam int LEN = 1 + V * H;

        logic       rst, start, resp, busy, done, pass, ffv;
        logic [2:0] stim, ffvec;
        logic [3:0] fail_count;
        int         mode;
        logic [2:0] fv;
        logic [7:0] mask;
        bit         gl;
        bit         finished = 0;
        logic       glitch_now;

        int         m_e      = 0;
        int         m_k      = 0;
        bit         m_active = 0;
        bit         m_init   = 0;
        logic [7:0] m_bad    = '0;

        boolean_bist #(
            .N_IN       (3),
            .EXPECTED   (8'b1110_1010),
            .HOLD_CYCLES(H)
        ) dut (
            .clk             (clk),
            .rst             (rst),
            .start           (start),
            .stim            (stim),
            .resp            (resp),
            .busy            (busy),
            .done            (done),
            .pass            (pass),
            .fail_count      (fail_count),
            .first_fail_valid(ffv),
            .first_fail_vec  (ffvec)
        );

        always_comb begin
            glitch_now = 1'b0;
            if (gl && m_active && (m_e - m_k) < V * H && ((m_e - m_k) % H) != H - 1) glitch_now = 1'b1;
        end

        assign resp = blk(stim, mode, fv, mask) ^ glitch_now;

        // m_k is the edge that accepted start; d = edges since then
        always @(posedge clk) begin
            logic [7:0] nb;
            m_e <= m_e + 1;
            if (rst) begin
                m_active <= 1'b0;
                m_init   <= 1'b1;
            end else if (start && (!m_active || (m_e - m_k) > V * H)) begin
                for (int v = 0; v < V; v++) nb[v] = (blk(3'(v), mode, fv, mask) != ref_fn(3'(v)));
                m_active <= 1'b1;
                m_k      <= m_e + 1;
                m_bad    <= nb;
            end
        end

        always @(negedge clk) begin
            if (m_init) begin
                int d, s, e_stim, nf, fb;
                bit e_busy, e_done, e_pass;
                e_busy = 0; e_done = 0; e_pass = 0; e_stim = 0; s = 0;
                if (m_active) begin
                    d = m_e - m_k;
                    if (d < V * H) begin
                        e_busy = 1;
                        s      = d / H;
                        e_stim = d / H;
                    end else begin
                        s      = V;
                        e_stim = V - 1;
                        e_done = (d == V * H);
                        e_pass = (count_bad(m_bad, V) == 0);
                    end
                end
                nf = count_bad(m_bad, s);
                fb = first_bad(m_bad, s);
                check("busy", g, int'(busy), int'(e_busy));
                check("done", g, int'(done), int'(e_done));
                check("stim", g, int'(stim), e_stim);
                check("fail_count", g, int'(fail_count), nf);
                check("first_fail_valid", g, int'(ffv), int'(fb >= 0));
                check("first_fail_vec", g, int'(ffvec), (fb < 0) ? 0 : fb);
                check("pass", g, int'(pass), int'(e_pass));
            end
        end

        task automatic sweep(input int md, input int fvv, input int mk, input bit g_l,
                             input int st1, input int st2, input int rst_at);
            int n;
            mode = md;
            fv   = 3'(fvv);
            mask = 8'(mk);
            gl   = g_l;
            @(posedge clk);
            #1 start = 1'b1;
            n = 0;
            while (n < LEN + 40) begin
                @(posedge clk);
                #1;
                n++;
                start = 1'b0;
                rst   = 1'b0;
                if (rst_at > 0 && n == rst_at + 1) begin
                    check("rst_busy", g, int'(busy), 0);
                    check("rst_stim", g, int'(stim), 0);
                    check("rst_fail_count", g, int'(fail_count), 0);
                    check("rst_done", g, int'(done), 0);
                    return;
                end
                if (done) break;
                if (n == st1 || n == st2) start = 1'b1;
                if (n == rst_at) rst = 1'b1;
            end
            check("sweep_len", g, n, LEN);
        endtask

        initial begin
            int md, fvv, mk, st1, st2, ra;
            bit gg;
            rst = 1'b1; start = 1'b0; mode = 0; fv = '0; mask = '0; gl = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("reset_busy", g, int'(busy), 0);
            check("reset_stim", g, int'(stim), 0);
            check("reset_fail_count", g, int'(fail_count), 0);
            check("reset_pass", g, int'(pass), 0);
            rst = 1'b0;

            sweep(0, 0, 0, 1'b0, 0, 0, 0);
            check("good_pass", g, int'(pass), 1);
            check("good_fail_count", g, int'(fail_count), 0);
            check("good_ffv", g, int'(ffv), 0);

            sweep(1, 0, 0, 1'b0, 0, 0, 0);
            check("stuck0_fail_count", g, int'(fail_count), 5);
            check("stuck0_ffvec", g, int'(ffvec), 1);
            check("stuck0_ffv", g, int'(ffv), 1);
            check("stuck0_pass", g, int'(pass), 0);

            sweep(2, 6, 0, 1'b0, 0, 0, 0);
            check("inv6_fail_count", g, int'(fail_count), 1);
            check("inv6_ffvec", g, int'(ffvec), 6);
            check("inv6_pass", g, int'(pass), 0);

            sweep(0, 0, 0, 1'b1, 0, 0, 0);
            check("glitch_pass", g, int'(pass), 1);
            check("glitch_fail_count", g, int'(fail_count), 0);

            sweep(1, 0, 0, 1'b0, (10 * H + 19) / 20, (40 * H + 19) / 20, (50 * H + 19) / 20);
            sweep(0, 0, 0, 1'b0, 0, 0, 0);
            check("after_rst_pass", g, int'(pass), 1);

            repeat (8) begin
                md  = int'($urandom_range(0, 3));
                fvv = int'($urandom_range(0, 7));
                mk  = int'($urandom_range(0, 255));
                gg  = 1'($urandom_range(0, 1));
                st1 = int'($urandom_range(1, V * H));
                st2 = int'($urandom_range(1, V * H));
                ra  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, V * H - 1)) : 0;
                sweep(md, fvv, mk, gg, st1, st2, ra);
            end
            finished = 1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(lane[0].finished && lane[1].finished) && cyc < 30000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 30000) begin
            checks++;
            failures++;
            $display("FAIL watchdog actual=%0d cycles expected=completion", cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
